// File: rtl/mandel_writer_if.sv
// Frame-buffer BRAM port-A write bus: write enable, pixel address and
// iteration-count data. The renderer drives it through the master modport.
interface mandel_writer_if #(
  parameter int DATA_W = 7
);
  logic              wea;
  logic [18:0]       addr_w;
  logic [DATA_W-1:0] dina;

  modport master (output wea, output addr_w, output dina);
  modport slave  (input  wea, input  addr_w, input  dina);
endinterface

// File: rtl/mandel_writer.sv
// Mandelbrot frame renderer. Walks the frame in raster order, runs one
// escape-time iteration per clock in Q4.12 fixed point and writes each
// pixel's iteration count into the frame-buffer BRAM through port A.
// Optional build macro LIVE_VIEW_EN: when defined, read_enable stays high
// from the first clock after reset so the display shows the frame while it
// is being drawn; otherwise the display is blanked until a frame completes.
module mandel_writer #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int MAX_ITER = 127,
  parameter int DATA_W   = 7,
  parameter int FRAC     = 12
) (
  input  logic               CLK_100MHz,
  input  logic               reset,
  input  logic               start,
  input  logic signed [15:0] x_min,
  input  logic signed [15:0] y_max,
  input  logic        [15:0] step,
  mandel_writer_if.master    bram,
  output logic               busy,
  output logic               done,
  output logic               read_enable
);

  localparam int                X_W      = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam logic [18:0]       LAST_PIX = 19'(H_RES * V_RES - 1);
  localparam logic [X_W-1:0]    LAST_X   = X_W'(H_RES - 1);
  localparam logic [DATA_W-1:0] ITER_CAP = DATA_W'(MAX_ITER);
  localparam logic [17:0]       ESC_MAG  = 18'(4 << FRAC);

  typedef enum logic [2:0] {IDLE, INIT, ITER, WRITE, DONE} state_t;

  // Fixed-point product: full 32-bit signed product, rescaled by an
  // arithmetic shift so negative cross terms round toward minus infinity.
  function automatic logic signed [31:0] fx_mul(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
    logic signed [31:0] p;
    p = 32'(a) * 32'(b);
    return p >>> FRAC;
  endfunction

  state_t state, state_n;

  logic signed [15:0] x_min_r;
  logic        [15:0] step_r;
  logic signed [15:0] cr, ci, zr, zi;
  logic        [18:0] pix;
  logic [X_W-1:0]     x;
  logic [DATA_W-1:0]  iter;

  logic signed [31:0] zr2, zi2, zri;
  logic        [17:0] mag;
  logic               escape;
  logic               last_pix;
  logic               start_ok;

  // Escape-time arithmetic for the current z and the frame-end condition.
  always_comb begin
    zr2      = fx_mul(zr, zr);
    zi2      = fx_mul(zi, zi);
    zri      = fx_mul(zr, zi);
    mag      = 18'(zr2 + zi2);
    escape   = (mag >= ESC_MAG) || (iter == ITER_CAP);
    last_pix = (pix == LAST_PIX);
    start_ok = ((state == IDLE) || (state == DONE)) && start;
  end

  // State register.
  always_ff @(posedge CLK_100MHz or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (start) state_n = INIT;
      INIT:       state_n = ITER;
      ITER:       if (escape) state_n = WRITE;
      WRITE:      state_n = last_pix ? DONE : INIT;
      default:    state_n = IDLE;
    endcase
  end

  // Coordinate walk, iteration datapath, BRAM write port and frame status.
  always_ff @(posedge CLK_100MHz or negedge reset) begin
    if (!reset) begin
      x_min_r     <= '0;
      step_r      <= '0;
      cr          <= '0;
      ci          <= '0;
      zr          <= '0;
      zi          <= '0;
      pix         <= '0;
      x           <= '0;
      iter        <= '0;
      bram.wea    <= 1'b0;
      bram.addr_w <= '0;
      bram.dina   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      bram.wea <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            x_min_r <= x_min;
            step_r  <= step;
            cr      <= x_min;
            ci      <= y_max;
            pix     <= '0;
            x       <= '0;
            busy    <= 1'b1;
          end
        end
        INIT: begin
          zr   <= '0;
          zi   <= '0;
          iter <= '0;
        end
        ITER: begin
          if (!escape) begin
            zr   <= 16'(zr2 - zi2 + 32'(cr));
            zi   <= 16'((zri <<< 1) + 32'(ci));
            iter <= iter + 1'b1;
          end
        end
        WRITE: begin
          bram.wea    <= 1'b1;
          bram.addr_w <= pix;
          bram.dina   <= iter;
          pix         <= pix + 1'b1;
          if (x == LAST_X) begin
            x  <= '0;
            cr <= x_min_r;
            ci <= ci - $signed(step_r);
          end else begin
            x  <= x + 1'b1;
            cr <= cr + $signed(step_r);
          end
          if (last_pix) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Display gating: blank an incomplete frame unless live view is built in.
  always_ff @(posedge CLK_100MHz or negedge reset) begin
`ifdef LIVE_VIEW_EN
    if (!reset) read_enable <= 1'b0;
    else        read_enable <= 1'b1;
`else
    if (!reset)                           read_enable <= 1'b0;
    else if (start_ok)                    read_enable <= 1'b0;
    else if ((state == WRITE) && last_pix) read_enable <= 1'b1;
`endif
  end

endmodule

// File: tb/tb_mandel_writer.sv
// Randomised self-checking bench for mandel_writer on a 4x2 frame.
module tb_mandel_writer;

  localparam int H     = 4;
  localparam int V     = 2;
  localparam int NPIX  = H * V;
  localparam int MAXIT = 127;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic signed [15:0] x_min = '0;
  logic signed [15:0] y_max = '0;
  logic        [15:0] step = '0;
  logic               busy, done, read_enable;

  mandel_writer_if #(.DATA_W(7)) bram ();

  mandel_writer #(
    .H_RES(H), .V_RES(V), .MAX_ITER(MAXIT), .DATA_W(7), .FRAC(12)
  ) dut (
    .CLK_100MHz (clk),
    .reset      (rst_n),
    .start      (start),
    .x_min      (x_min),
    .y_max      (y_max),
    .step       (step),
    .bram       (bram),
    .busy       (busy),
    .done       (done),
    .read_enable(read_enable)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference escape-time count from the real-number recurrence evaluated
  // on Q4.12 integers (valid for |cr|,|ci| <= 2 where nothing wraps).
  function automatic int mandel_iters(input int cr, input int ci);
    int zr, zi, zr2, zi2, zri, nzr;
    zr = 0;
    zi = 0;
    for (int k = 0; k < MAXIT; k++) begin
      zr2 = (zr * zr) >>> 12;
      zi2 = (zi * zi) >>> 12;
      zri = (zr * zi) >>> 12;
      if (zr2 + zi2 >= 4 * 4096) return k;
      nzr = zr2 - zi2 + cr;
      zi  = 2 * zri + ci;
      zr  = nzr;
    end
    return MAXIT;
  endfunction

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t exp_q[$];
  bit  chk_en   = 1'b0;
  bit  frame_on = 1'b0;
  bit  re_idle  = 1'b0;
  int  start_cyc = 0;
  int  done_cyc  = 0;

  // Start a frame and predict every write (address, count, cycle).
  task automatic launch(input int xm, input int ym, input int st);
    int t, cr, ci, k;
    @(negedge clk);
    if (frame_on) re_idle = 1'b1;
    x_min = 16'(xm);
    y_max = 16'(ym);
    step  = 16'(st);
    start = 1'b1;
    t = cyc + 1;
    start_cyc = t;
    exp_q.delete();
    for (int p = 0; p < NPIX; p++) begin
      cr = xm + (p % H) * st;
      ci = ym - (p / H) * st;
      k  = mandel_iters(cr, ci);
      t  = t + k + 3;
      exp_q.push_back('{p, k, t});
    end
    done_cyc = t;
    frame_on = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x_min = 16'($urandom);
    y_max = 16'($urandom);
    step  = 16'($urandom);
  endtask

  task automatic wait_frame();
    int guard;
    guard = 0;
    while (cyc < done_cyc + 3 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("frame_end_reached", cyc >= done_cyc + 3, 1);
    check("all_writes_seen", exp_q.size(), 0);
  endtask

  // Per-cycle comparison of the DUT against the predicted frame.
  always @(posedge clk) begin
    wr_t e;
    bit  re_exp;
    #1;
    if (chk_en) begin
      if (bram.wea) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("addr_w", bram.addr_w, e.addr);
          check("dina", bram.dina, e.data);
          check("write_cycle", cyc, e.cyc);
        end
      end
      check("done", done, frame_on && cyc == done_cyc);
      check("busy", busy, frame_on && cyc >= start_cyc && cyc < done_cyc);
`ifdef LIVE_VIEW_EN
      re_exp = 1'b1;
`else
      if (frame_on && cyc >= start_cyc) re_exp = (cyc >= done_cyc);
      else                              re_exp = re_idle;
`endif
      check("read_enable", read_enable, re_exp);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, xm, ym;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wea", bram.wea, 0);
    check("rst_addr", bram.addr_w, 0);
    check("rst_dina", bram.dina, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_re", read_enable, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Literal pins on the reference model
    check("pin_c_1", mandel_iters(4096, 0), 2);
    check("pin_c_0", mandel_iters(0, 0), 127);
    check("pin_c_m2", mandel_iters(-8192, 0), 1);
    check("pin_c_i", mandel_iters(0, 4096), 127);
    check("pin_c_half", mandel_iters(2048, 2048), 5);

    // Escaping point: 5 cycles per pixel
    launch(4096, 0, 0);
    check("esc_first_lat", exp_q[0].cyc - start_cyc, 5);
    check("esc_frame_len", done_cyc - start_cyc, 5 * NPIX);
    wait_frame();

    // Interior point: 130 cycles per pixel, restarted from DONE
    launch(0, 0, 0);
    check("int_first_lat", exp_q[0].cyc - start_cyc, 130);
    check("int_frame_len", done_cyc - start_cyc, 130 * NPIX);
    wait_frame();

    // Raster walk and row wrap
    launch(-8192, 4096, 2048);
    wait_frame();

    // start while busy must be ignored
    launch(-4096, 2048, 512);
    repeat (10) @(negedge clk);
    x_min = 16'sh1000;
    y_max = 16'sh0000;
    step  = 16'h0100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_frame();

    // Reset in the middle of a long frame
    launch(0, 0, 0);
    repeat (300) @(negedge clk);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wea", bram.wea, 0);
    check("mid_rst_addr", bram.addr_w, 0);
    check("mid_rst_dina", bram.dina, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_re", read_enable, 0);
    @(negedge clk);
    exp_q.delete();
    frame_on = 1'b0;
    re_idle  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    launch(4096, 0, 0);
    wait_frame();

    // Randomised frames inside the valid coordinate range
    for (int n = 0; n < 10; n++) begin
      st = int'($urandom_range(1024, 0));
      xm = -8192 + int'($urandom_range(16384 - 3 * st, 0));
      ym = 8192 - int'($urandom_range(16384 - st, 0));
      launch(xm, ym, st);
      wait_frame();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mandel_writer.md
Name: mandel_writer

Overview:
- Write-side producer for the 640x480 frame-buffer BRAM; the display path reads the same BRAM on port B.
- Renders the Mandelbrot set in raster order, one escape-time iteration per clock, in signed fixed point.
- Writes each pixel's 7-bit iteration count through BRAM port A using wea/addr_w/dina.
- Drives the display path's read_enable so an incomplete frame is blanked.

Parameters:
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame; H_RES*V_RES must be at most 2^19.
- MAX_ITER, 127, iteration cap; must fit in DATA_W bits.
- DATA_W, 7, width of dina.
- FRAC, 12, fraction bits of the 16-bit signed coordinate format (Q4.12).

Ports:
- CLK_100MHz  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to render one frame
- x_min  in  16  signed Q4.12, real part of column 0
- y_max  in  16  signed Q4.12, imaginary part of row 0
- step  in  16  unsigned Q4.12, per-pixel increment on both axes
- wea  out  1  BRAM port-A write enable
- addr_w  out  19  BRAM port-A address, y*H_RES+x
- dina  out  DATA_W  BRAM port-A data, iteration count
- busy  out  1  frame render in progress
- done  out  1  single-cycle pulse after the last pixel is written
- read_enable  out  1  frame valid for display

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; wea, addr_w, dina, busy, done and read_enable all 0; all coordinate and iteration registers cleared.
- Reset mid-frame aborts the render immediately. There is no resume; the next start begins at addr_w=0.
- States: IDLE, INIT, ITER, WRITE, DONE.
- IDLE or DONE, start=1:
  - latch x_min, y_max and step;
  - set cr=x_min, ci=y_max, pixel counter=0, x=0, y=0;
  - busy=1, read_enable=0;
  - go to INIT.
- start while busy is ignored, and inputs are not re-latched.
- INIT (1 cycle): zr=zi=0, iter=0; go to ITER.
- ITER, one test-and-update per cycle:
  - compute zr2=(zr*zr)>>>FRAC, zi2=(zi*zi)>>>FRAC and zri=(zr*zi)>>>FRAC; products are 32-bit signed and the shift is arithmetic;
  - mag = zr2+zi2, evaluated at 18 bits so it cannot overflow;
  - if mag >= (4<<FRAC) or iter==MAX_ITER, go to WRITE;
  - otherwise zr<=zr2-zi2+cr, zi<=(zri<<1)+ci, iter<=iter+1, truncated to 16 bits.
- Coordinates are valid for |cr| and |ci| up to 2.0. Outside that range the result wraps and is not flagged.
- WRITE (1 cycle): wea=1, addr_w=pixel counter, dina=iter[DATA_W-1:0]. In the same cycle:
  - pixel counter +1;
  - if x==H_RES-1: x=0, cr=x_min, y+1, ci=ci-step; else x+1, cr=cr+step;
  - if this was pixel H_RES*V_RES-1, go to DONE; else go to INIT.
- wea is high only in WRITE cycles. addr_w and dina hold their values between writes.
- The address comes from an incrementing counter; no multiplier is used.
- Pixel cost: 1 INIT + (k+1) ITER + 1 WRITE cycles, where k is the written count.
- Final WRITE to DONE: the next cycle has done=1 for exactly one cycle, busy=0 and read_enable=1. State stays DONE until start or reset.
- When iter reaches MAX_ITER and the escape test fires in the same cycle, the written value is MAX_ITER.

Optional Feature:
- Macro: LIVE_VIEW_EN.
- Defined: read_enable is forced to 1 after reset deassertion and stays 1 during rendering, so the frame is displayed progressively.
- Undefined: read_enable is 0 from reset or start until the done cycle, then 1 until the next start.

Test Plan:
- Reset: assert reset=0 mid-render -> wea=0, addr_w=0, dina=0, busy=0, done=0, read_enable=0 within the same cycle. Deassert and start -> first write at addr_w=0.
- Interior point: x_min=0, y_max=0, step=0, start -> every write has dina=127. Each pixel takes 130 cycles; the first wea occurs 130 cycles after entering INIT.
- Escaping point: x_min=0x1000 (1.0), y_max=0, step=0 -> every write has dina=2, each pixel takes 5 cycles, and the frame has exactly 307200 writes. Last addr_w=307199, then done pulses once and read_enable=1.
- Raster/wrap: H_RES=4, V_RES=2, x_min=0xE000 (-2.0), y_max=0x1000, step=0x0800 -> addr_w sequence 0..7. Writes 4..7 use ci=0x0800, and column 0 of row 1 uses cr=0xE000.
- start pulsed while busy -> no restart, address sequence uninterrupted, exactly one done pulse. start while in DONE -> new frame, read_enable drops to 0 (LIVE_VIEW_EN undefined).
- LIVE_VIEW_EN defined, repeat the escaping-point test -> read_enable stays 1 throughout; wea and done timing are identical.
